// File: rtl/iter_mul_div_if.sv
// ---------------------------------------------------------------------------
// iter_mul_div_if
//   Request/response bundle between the EX stage and the iterative
//   multiply/divide unit.
//
//   Handshake: a request is taken on a rising clock edge when start=1,
//   busy=0 and flush=0 (op/src_a/src_b are sampled on that edge). While
//   busy=1 any start is ignored and never queued. The result is valid on
//   hi_out/lo_out/div_by_zero in the single cycle where done=1, and
//   we_hi/we_lo mirror done. flush cancels an operation in flight.
//
//   Signals (master = requester, slave = unit):
//     start, op[1:0], src_a, src_b, flush   master -> slave
//     busy, done, we_hi, we_lo,
//     hi_out, lo_out, div_by_zero           slave  -> master
// ---------------------------------------------------------------------------
interface iter_mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, we_hi, we_lo, hi_out, lo_out, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, we_hi, we_lo, hi_out, lo_out, div_by_zero
  );
endinterface

// File: rtl/iter_mul_div.sv
// ---------------------------------------------------------------------------
// iter_mul_div
//   Multi-cycle MULT/MULTU/DIV/DIVU unit. Works on operand magnitudes:
//   radix-2 shift-add multiply and restoring divide, one bit per cycle,
//   followed by a sign fix-up cycle. op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
//   HI/LO = product[2W-1:W]/product[W-1:0] or remainder/quotient.
//   Divide by zero finishes the cycle after accept with lo=all ones,
//   hi=src_a and div_by_zero=1.
//
//   Optional feature: define MULDIV_FAST_MUL_EN to replace the iterative
//   multiply with a single-cycle WIDTHxWIDTH multiplier (MUL lasts 1 cycle).
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     bus          iter_mul_div_if.slave (request, flush, results, strobes)
//     dbg_state_o  current FSM state (IDLE=0 MUL=1 DIV=2 FIX=3 DONE=4)
// ---------------------------------------------------------------------------
module iter_mul_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  iter_mul_div_if.slave bus,
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  // MUL: {partial product high, multiplier shifting out}.
  // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  // Operand conditioning at accept. Signs are only recorded for signed ops,
  // so the fix-up stage needs no knowledge of the opcode.
  logic             in_signed, a_neg_in, b_neg_in, accept;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign accept    = bus.start & ~bus.flush;
  assign in_signed = ~bus.op[0];
  assign a_neg_in  = in_signed & bus.src_a[WIDTH-1];
  assign b_neg_in  = in_signed & bus.src_b[WIDTH-1];
  // MIN maps onto itself, which read as unsigned is the correct magnitude.
  assign a_abs     = a_neg_in ? (~bus.src_a + ONE_W) : bus.src_a;
  assign b_abs     = b_neg_in ? (~bus.src_b + ONE_W) : bus.src_b;

  // Multiply step
  logic [2*WIDTH-1:0] mul_next;
`ifdef MULDIV_FAST_MUL_EN
  assign mul_next = {{WIDTH{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q};
`else
  // Add multiplicand into the high half when the multiplier LSB is set,
  // then shift the whole register right, keeping the carry.
  logic [WIDTH:0] mul_sum;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, a_mag_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`endif

  // Restoring divide step: shift in the next dividend bit and try to
  // subtract the divisor; keep the difference only if it is non-negative.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, b_mag_q};
  assign div_ok    = ~div_trial[WIDTH+1];
  assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};

  // Sign fix-up
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = res_neg_q ? (~acc_q + ONE_2W) : acc_q;
  assign quo_fix  = res_neg_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W)
                              : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = bus.op;
          a_mag_d   = a_abs;
          b_mag_d   = b_abs;
          res_neg_d = a_neg_in ^ b_neg_in;
          rem_neg_d = a_neg_in;
          cnt_d     = '0;
          if (bus.op[1]) begin
            acc_d = {{WIDTH{1'b0}}, a_abs};
            if (bus.src_b == '0) begin
              hi_d    = bus.src_a;
              lo_d    = '1;
              dbz_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            acc_d   = {{WIDTH{1'b0}}, b_abs};
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_next;
`ifdef MULDIV_FAST_MUL_EN
          state_d = S_FIX;
`else
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_END) state_d = S_FIX;
`endif
        end
      end

      S_DIV: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_END) state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      // Result is already committed here, so flush has no effect.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.we_hi       = (state_q == S_DONE);
  assign bus.we_lo       = (state_q == S_DONE);
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state_o     = state_q;

endmodule
